// File: rtl/jump_pkg.sv
// Shared decode constants and RAS operation type for the jump execution unit.
package jump_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR  = 3'b000;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_t;

  // x1 and x5 are the architectural link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/jump_ras.sv
// Return-address stack: circular storage, top-of-stack pointer, saturating count.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   op_i            stack operation this cycle
//   push_data_i     value written on push / pop-push
//   clear_i         empties the stack (entries left stale)
//   top_o           current top entry (pre-update state)
//   nonempty_o      count is non-zero
module jump_ras
  import jump_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  ras_op_t         op_i,
  input  logic [PC_W-1:0] push_data_i,
  input  logic            clear_i,
  output logic [PC_W-1:0] top_o,
  output logic            nonempty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o      = stack_q[tos_q];
  assign nonempty_o = !empty;

  // Pointer/count update; a push on a full stack overwrites the oldest slot.
  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = tos_q + PTR_W'(1);
    if (clear_i) begin
      cnt_d = '0;
    end else begin
      unique case (op_i)
        RAS_PUSH: begin
          wr_en = 1'b1;
          tos_d = tos_q + PTR_W'(1);
          cnt_d = full ? cnt_q : cnt_q + CNT_W'(1);
        end
        RAS_POP: begin
          if (!empty) begin
            tos_d = tos_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RAS_POPPUSH: begin
          // Non-empty: replace top in place. Empty: degenerates to a push.
          wr_en = 1'b1;
          if (empty) begin
            tos_d = tos_q + PTR_W'(1);
            cnt_d = CNT_W'(1);
          end else begin
            wr_ptr = tos_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      stack_q[wr_ptr] <= push_data_i;
    end
  end

endmodule

// File: rtl/jump_unit.sv
// JAL/JALR execution unit with return-address-stack prediction, 1-cycle latency.
// Ports:
//   iCLK, iRST_N            clock, async active-low reset
//   iVALID/iIR/iPC/iRS1     decoded instruction, its PC and rs1 value
//   iFLUSH                  kills this cycle's instruction and empties the RAS
//   oVALID                  registered outputs belong to an accepted jump
//   oRD/oRD_WE/oREG_IN      link writeback
//   oPCBR/oTAKEN/oMISALIGN  resolved target, redirect, misalignment exception
//   oPRED_VALID/oPRED_PC/oPRED_HIT  RAS prediction and its agreement with oPCBR
module jump_unit
  import jump_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iVALID,
  input  logic [31:0]     iIR,
  input  logic [PC_W-1:0] iPC,
  input  logic [XLEN-1:0] iRS1,
  input  logic            iFLUSH,
  output logic            oVALID,
  output logic [4:0]      oRD,
  output logic            oRD_WE,
  output logic [XLEN-1:0] oREG_IN,
  output logic [PC_W-1:0] oPCBR,
  output logic            oTAKEN,
  output logic            oMISALIGN,
  output logic            oPRED_VALID,
  output logic [PC_W-1:0] oPRED_PC,
  output logic            oPRED_HIT
);

  logic [4:0]         rd, rs1;
  logic               is_jal, is_jalr, accept;
  logic signed [31:0] imm_j, imm_i;
  logic [PC_W-1:0]    jalr_sum, target, link;
  logic               misalign;
  ras_op_t            ras_op;
  logic [PC_W-1:0]    ras_top;
  logic               ras_nonempty;

  logic            valid_d, valid_q;
  logic [4:0]      rd_d, rd_q;
  logic            rd_we_d, rd_we_q;
  logic [XLEN-1:0] reg_in_d, reg_in_q;
  logic [PC_W-1:0] pcbr_d, pcbr_q;
  logic            taken_d, taken_q;
  logic            misalign_d, misalign_q;
  logic            pred_valid_d, pred_valid_q;
  logic [PC_W-1:0] pred_pc_d, pred_pc_q;
  logic            pred_hit_d, pred_hit_q;

  assign rd      = iIR[11:7];
  assign rs1     = iIR[19:15];
  assign is_jal  = (iIR[6:0] == OPC_JAL);
  assign is_jalr = (iIR[6:0] == OPC_JALR) && (iIR[14:12] == F3_JALR);
  assign accept  = iVALID && !iFLUSH && (is_jal || is_jalr);

  // Immediates held as signed 32-bit so the PC_W cast sign-extends or truncates.
  assign imm_j    = {{11{iIR[31]}}, iIR[31], iIR[19:12], iIR[20], iIR[30:21], 1'b0};
  assign imm_i    = {{20{iIR[31]}}, iIR[31:20]};
  assign jalr_sum = PC_W'(iRS1) + PC_W'(imm_i);
  assign target   = is_jal ? (iPC + PC_W'(imm_j)) : {jalr_sum[PC_W-1:1], 1'b0};
  assign link     = iPC + PC_W'(32'd4);
  assign misalign = target[1];

  // Link-register hint classification; misaligned jumps leave the RAS alone.
  always_comb begin
    ras_op = RAS_NONE;
    if (accept && !misalign) begin
      if (is_jal) begin
        if (is_link(rd)) ras_op = RAS_PUSH;
      end else begin
        unique case ({is_link(rd), is_link(rs1)})
          2'b01:   ras_op = RAS_POP;
          2'b10:   ras_op = RAS_PUSH;
          2'b11:   ras_op = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
          default: ras_op = RAS_NONE;
        endcase
      end
    end
  end

  jump_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (iCLK),
    .rst_ni      (iRST_N),
    .op_i        (ras_op),
    .push_data_i (link),
    .clear_i     (iFLUSH),
    .top_o       (ras_top),
    .nonempty_o  (ras_nonempty)
  );

  // Next output values; everything stays zero unless a jump is accepted.
  always_comb begin
    valid_d      = 1'b0;
    rd_d         = '0;
    rd_we_d      = 1'b0;
    reg_in_d     = '0;
    pcbr_d       = '0;
    taken_d      = 1'b0;
    misalign_d   = 1'b0;
    pred_valid_d = 1'b0;
    pred_pc_d    = '0;
    pred_hit_d   = 1'b0;
    if (accept) begin
      valid_d    = 1'b1;
      rd_d       = rd;
      rd_we_d    = !misalign && (rd != 5'd0);
      reg_in_d   = XLEN'(link);
      pcbr_d     = target;
      taken_d    = !misalign;
      misalign_d = misalign;
      if ((ras_op == RAS_POP || ras_op == RAS_POPPUSH) && ras_nonempty) begin
        pred_valid_d = 1'b1;
        pred_pc_d    = ras_top;
        pred_hit_d   = (ras_top == target);
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      reg_in_q     <= '0;
      pcbr_q       <= '0;
      taken_q      <= 1'b0;
      misalign_q   <= 1'b0;
      pred_valid_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_hit_q   <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      reg_in_q     <= reg_in_d;
      pcbr_q       <= pcbr_d;
      taken_q      <= taken_d;
      misalign_q   <= misalign_d;
      pred_valid_q <= pred_valid_d;
      pred_pc_q    <= pred_pc_d;
      pred_hit_q   <= pred_hit_d;
    end
  end

  assign oVALID      = valid_q;
  assign oRD         = rd_q;
  assign oRD_WE      = rd_we_q;
  assign oREG_IN     = reg_in_q;
  assign oPCBR       = pcbr_q;
  assign oTAKEN      = taken_q;
  assign oMISALIGN   = misalign_q;
  assign oPRED_VALID = pred_valid_q;
  assign oPRED_PC    = pred_pc_q;
  assign oPRED_HIT   = pred_hit_q;

endmodule

// File: tb/tb_jump_unit.sv
// Scoreboard bench for jump_unit: driver pushes model results, monitor pops and compares.
module tb_jump_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 4;

  logic            iCLK = 1'b0;
  logic            iRST_N;
  logic            iVALID;
  logic [31:0]     iIR;
  logic [PC_W-1:0] iPC;
  logic [XLEN-1:0] iRS1;
  logic            iFLUSH;
  logic            oVALID;
  logic [4:0]      oRD;
  logic            oRD_WE;
  logic [XLEN-1:0] oREG_IN;
  logic [PC_W-1:0] oPCBR;
  logic            oTAKEN;
  logic            oMISALIGN;
  logic            oPRED_VALID;
  logic [PC_W-1:0] oPRED_PC;
  logic            oPRED_HIT;

  jump_unit #(.XLEN(XLEN), .PC_W(PC_W), .RAS_DEPTH(DEPTH)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iVALID      (iVALID),
    .iIR         (iIR),
    .iPC         (iPC),
    .iRS1        (iRS1),
    .iFLUSH      (iFLUSH),
    .oVALID      (oVALID),
    .oRD         (oRD),
    .oRD_WE      (oRD_WE),
    .oREG_IN     (oREG_IN),
    .oPCBR       (oPCBR),
    .oTAKEN      (oTAKEN),
    .oMISALIGN   (oMISALIGN),
    .oPRED_VALID (oPRED_VALID),
    .oPRED_PC    (oPRED_PC),
    .oPRED_HIT   (oPRED_HIT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] reg_in;
    logic [31:0] pcbr;
    logic        taken;
    logic        mis;
    logic        pv;
    logic [31:0] ppc;
    logic        hit;
  } res_t;

  res_t        exp_q[$];
  bit   [31:0] ras[$];
  int          checks = 0;
  int          errors = 0;

  function automatic res_t sample();
    res_t a;
    a = '{v: oVALID, rd: oRD, we: oRD_WE, reg_in: oREG_IN, pcbr: oPCBR, taken: oTAKEN,
          mis: oMISALIGN, pv: oPRED_VALID, ppc: oPRED_PC, hit: oPRED_HIT};
    return a;
  endfunction

  function automatic bit lnk(input bit [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Reference behaviour: offsets as plain integers, RAS as a bounded queue.
  function automatic res_t model(input bit v, input bit fl, input bit [31:0] ir,
                                 input bit [31:0] pc, input bit [31:0] rs1v);
    res_t e = '0;
    bit   is_jal, is_jalr, pop, push;
    int   off;
    bit [31:0] tgt;
    bit [4:0]  rd, rs;
    if (fl) begin
      ras.delete();
      return e;
    end
    is_jal  = (ir[6:0] == 7'h6F);
    is_jalr = (ir[6:0] == 7'h67) && (ir[14:12] == 3'd0);
    if (!v || !(is_jal || is_jalr)) return e;
    rd = ir[11:7];
    rs = ir[19:15];
    if (is_jal) begin
      off = int'({ir[19:12], ir[20], ir[30:21], 1'b0}) - (ir[31] ? (1 << 20) : 0);
      tgt = pc + 32'(off);
    end else begin
      off = int'(ir[30:20]) - (ir[31] ? 2048 : 0);
      tgt = (rs1v + 32'(off)) & ~32'd1;
    end
    e.v      = 1'b1;
    e.rd     = rd;
    e.reg_in = pc + 32'd4;
    e.pcbr   = tgt;
    e.mis    = tgt[1];
    e.taken  = !tgt[1];
    e.we     = !tgt[1] && (rd != 5'd0);
    if (!tgt[1]) begin
      pop  = is_jalr && lnk(rs) && !(lnk(rd) && rs == rd);
      push = lnk(rd);
      if (pop && ras.size() > 0) begin
        e.pv  = 1'b1;
        e.ppc = ras.pop_back();
        e.hit = (e.ppc == tgt);
      end
      if (push) begin
        ras.push_back(pc + 32'd4);
        if (ras.size() > DEPTH) void'(ras.pop_front());
      end
    end
    return e;
  endfunction

  function automatic bit [31:0] enc_jal(input bit [4:0] rd, input bit [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic bit [31:0] enc_jalr(input bit [4:0] rd, input bit [4:0] rs,
                                         input bit [11:0] imm, input bit [2:0] f3);
    return {imm, rs, f3, rd, 7'h67};
  endfunction

  function automatic bit [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic report(input string name, input res_t a, input res_t e);
    $display("FAIL %s: got v=%0b rd=%0d we=%0b link=%h tgt=%h tk=%0b mis=%0b pv=%0b ppc=%h hit=%0b; expected v=%0b rd=%0d we=%0b link=%h tgt=%h tk=%0b mis=%0b pv=%0b ppc=%h hit=%0b",
             name, a.v, a.rd, a.we, a.reg_in, a.pcbr, a.taken, a.mis, a.pv, a.ppc, a.hit,
             e.v, e.rd, e.we, e.reg_in, e.pcbr, e.taken, e.mis, e.pv, e.ppc, e.hit);
  endtask

  task automatic chk_zero(input string name);
    res_t a;
    a = sample();
    checks++;
    if (a !== res_t'('0)) begin
      errors++;
      report(name, a, '0);
    end
  endtask

  task automatic step(input bit v, input bit fl, input bit [31:0] ir,
                      input bit [31:0] pc, input bit [31:0] rs1v);
    @(negedge iCLK);
    iVALID = v;
    iFLUSH = fl;
    iIR    = ir;
    iPC    = pc;
    iRS1   = rs1v;
    exp_q.push_back(model(v, fl, ir, pc, rs1v));
  endtask

  // Monitor: every cycle the registered outputs are compared with the oldest expectation.
  initial begin
    res_t a, e;
    int   n = 0;
    forever begin
      @(posedge iCLK);
      #1;
      a = sample();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        n++;
        if (a !== e) begin
          errors++;
          report($sformatf("out#%0d", n), a, e);
        end
      end else if (iRST_N) begin
        checks++;
        if (a !== res_t'('0)) begin
          errors++;
          report("idle", a, '0);
        end
      end
    end
  end

  initial begin
    bit [31:0] ir, pc, rv;
    bit [4:0]  rd, rs;
    iRST_N = 1'b0;
    iVALID = 1'b0;
    iFLUSH = 1'b0;
    iIR    = '0;
    iPC    = '0;
    iRS1   = '0;
    #12;
    chk_zero("reset");
    @(negedge iCLK);
    iRST_N = 1'b1;

    // Call then return.
    step(1, 0, 32'h008000EF, 32'h100, 32'h0);
    step(1, 0, 32'h00008067, 32'h200, 32'h104);
    // Misaligned returns through x5.
    step(1, 0, 32'h00028067, 32'h300, 32'h202);
    step(1, 0, 32'h00028067, 32'h300, 32'h203);
    // Overflow: five calls into a four-deep stack, then five returns.
    for (int i = 0; i < 5; i++) step(1, 0, 32'h008000EF, 32'(i * 16), 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 32'h00008067, 32'h500, 32'(32'h44 - i * 16));
    // Flush with a valid call, then a return sees an empty stack.
    step(1, 0, 32'h008000EF, 32'h600, 32'h0);
    step(1, 1, 32'h008000EF, 32'h700, 32'h0);
    step(1, 0, 32'h00008067, 32'h800, 32'h604);
    // Non-jump and bad-funct3 JALR are ignored.
    step(1, 0, 32'h00000013, 32'h900, 32'h0);
    step(1, 0, enc_jalr(5'd1, 5'd1, 12'h010, 3'd1), 32'h904, 32'h100);

    // Asynchronous reset in the middle of back-to-back calls.
    for (int i = 0; i < 3; i++) step(1, 0, 32'h008000EF, 32'(32'hA00 + i * 4), 32'h0);
    @(posedge iCLK);
    #3;
    iRST_N = 1'b0;
    #1;
    chk_zero("async_reset");
    ras.delete();
    @(negedge iCLK);
    iVALID = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    step(1, 0, 32'h00008067, 32'hB00, 32'hA0C);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rd = pick_reg();
      rs = pick_reg();
      pc = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & ~32'd3);
      rv = $urandom;
      if (ras.size() > 0 && $urandom_range(0, 1) == 1) rv = ras[ras.size() - 1];
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ir = enc_jal(rd, 21'($urandom));
        4, 5, 6, 7: ir = enc_jalr(rd, rs, ($urandom_range(0, 1) == 1) ? 12'h0 : 12'($urandom),
                                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
        default:    ir = $urandom;
      endcase
      step($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, ir, pc, rv);
    end
    step(0, 0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge iCLK);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jump_unit.md
# jump_unit

Registered, parametrised jump-execution unit for the RV32I core, handling both JAL and JALR, with a return-address stack (RAS) that predicts return targets. It sits in the ALU execute stage, parallel to the other instruction-class units. It takes a decoded-stage instruction, PC and rs1 value. One cycle later it presents the link value, resolved target, misalignment flag and RAS prediction to writeback and fetch.

## Interface
- XLEN, 32, register/data width
- PC_W, 32, PC width; PC_W ≤ XLEN
- RAS_DEPTH, 4, RAS entries; power of two, ≥ 2
- iCLK  in  1  clock, all state updates on rising edge
- iRST_N  in  1  reset; asynchronous, active-low
- iVALID  in  1  iIR/iPC/iRS1 are valid this cycle
- iIR  in  32  instruction word
- iPC  in  PC_W  PC of iIR
- iRS1  in  XLEN  rs1 read value (JALR only)
- iFLUSH  in  1  pipeline flush; kills the accepted instruction and empties the RAS
- oVALID  out  1  registered outputs belong to a jump accepted last cycle
- oRD  out  5  destination register index
- oRD_WE  out  1  write oREG_IN to oRD
- oREG_IN  out  XLEN  link value PC+4, zero-extended
- oPCBR  out  PC_W  resolved jump target
- oTAKEN  out  1  redirect fetch to oPCBR
- oMISALIGN  out  1  target misaligned; raise exception
- oPRED_VALID  out  1  oPRED_PC holds a RAS prediction
- oPRED_PC  out  PC_W  popped RAS entry
- oPRED_HIT  out  1  oPRED_PC == oPCBR

## Operation
- Accept when iVALID and opcode is JAL (1101111) or JALR (1100111, funct3 000). A non-jump or a JALR with a bad funct3 is ignored: next oVALID=0, no RAS change.
- JAL immediate: sign-extended {ir[31], ir[19:12], ir[20], ir[30:21], 0}. Target = iPC + imm.
- JALR immediate: sign-extended ir[31:20]. Target = (iRS1 + imm) with bit 0 cleared.
- All arithmetic is done modulo 2^PC_W; the low PC_W bits are taken.
- Link = iPC + 4, truncated to PC_W, then zero-extended to XLEN.
- Misalign: target bit 1 set (no C extension). Sets oMISALIGN=1, oTAKEN=0 and oRD_WE=0; there is no RAS action.
- Otherwise oTAKEN=1 and oRD_WE = (rd ≠ 0).
- Link registers are x1 and x5. RAS action:
  - JAL, rd link: push link.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd link, rs1 not link: push.
  - JALR, both link, rs1 ≠ rd: pop then push. The same cycle returns the old top and writes the new link in its slot.
  - JALR, both link, rs1 = rd: push.
  - Any other case: no action.
- Pop with count > 0: oPRED_VALID=1 and oPRED_PC = top. Pop on an empty RAS: oPRED_VALID=0 and count stays 0.
- Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
- iFLUSH, including when it coincides with iVALID: flush wins. Next oVALID=0, count goes to 0 and the entries are left stale.

## Timing
- Latency is 1 cycle; throughput is 1 instruction per cycle; there is no stall input.
- All outputs come from registers. When oVALID=0, every other output is 0.
- Reset value of every output and of the RAS count is 0.
- Asserting iRST_N low mid-stream clears the outputs immediately (asynchronously). Any in-flight instruction is lost.
- RAS prediction uses the state before this cycle's update. Back-to-back push then pop sees the pushed value.

## Structure
- Package jump_pkg holds:
  - OPC_JAL, OPC_JALR and F3_JALR constants;
  - the LINK_X1 and LINK_X5 indices;
  - the enum ras_op_t {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
- Sub-module jump_ras is parametrised by PC_W and RAS_DEPTH. It takes the op, push data and clear, and returns top and nonempty. It holds the top-of-stack pointer and a saturating count.
- jump_unit holds the decode, the immediate/target adders, the classification and the output registers.

## Test plan
- iPC=0x100, iIR=0x008000EF (jal x1,8) → oPCBR=0x108, oREG_IN=0x104, oRD=1, oRD_WE=1, oTAKEN=1, RAS pushes 0x104.
- Next cycle, iIR=0x00008067 (jalr x0,0(x1)), iRS1=0x104 → oPCBR=0x104, oRD_WE=0, oPRED_VALID=1, oPRED_PC=0x104, oPRED_HIT=1, RAS empty.
- iIR=0x00028067, iRS1=0x202 → oMISALIGN=1, oTAKEN=0, oRD_WE=0, RAS unchanged. iRS1=0x203 → target 0x202, same result.
- Five pushes of jal x1 from PC 0x0, 0x10, 0x20, 0x30, 0x40, then five returns:
  - the first four returns predict 0x44, 0x34, 0x24, 0x14;
  - the fifth gives oPRED_VALID=0.
- iFLUSH asserted with a valid JAL → next oVALID=0 and all outputs 0. A following return gives oPRED_VALID=0.
- Assert iRST_N low during a stream of back-to-back JALs → outputs go to 0 without waiting for a clock edge. After release, the first return gives oPRED_VALID=0.
